// File: rtl/ddr_pcie_dma_pkg.sv
// Shared types and constants for the DDR-to-PCIe write DMA controller.
package ddr_pcie_dma_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_DATA, ST_REQ, ST_WAIT_ACK, ST_XFER, ST_DONE
  } dma_state_e;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned WORD_BYTES     = 8;

  function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/ddr_pcie_dma_controller_if.sv
// Control, Tx-engine and DDR read FIFO signals of the DMA controller.
// master = controller side, slave = environment side.
interface ddr_pcie_dma_controller_if;
  logic        ctrl_en_i;
  logic [31:0] dma_dst_addr_i;
  logic [31:0] dma_len_i;
  logic        dma_done_o;
  logic        dma_done_ack_i;
  logic        dma_wr_req_o;
  logic        dma_wr_req_ack_i;
  logic [11:0] dma_wr_req_len_o;
  logic [31:0] dma_wr_req_addr_o;
  logic        dma_wr_data_rd_i;
  logic [63:0] dma_wr_data_o;
  logic        fifo_rd_o;
  logic [63:0] fifo_data_i;
  logic [10:0] fifo_data_cnt_i;

  modport master (
    input  ctrl_en_i, dma_dst_addr_i, dma_len_i, dma_done_ack_i, dma_wr_req_ack_i,
           dma_wr_data_rd_i, fifo_data_i, fifo_data_cnt_i,
    output dma_done_o, dma_wr_req_o, dma_wr_req_len_o, dma_wr_req_addr_o,
           dma_wr_data_o, fifo_rd_o
  );
  modport slave (
    output ctrl_en_i, dma_dst_addr_i, dma_len_i, dma_done_ack_i, dma_wr_req_ack_i,
           dma_wr_data_rd_i, fifo_data_i, fifo_data_cnt_i,
    input  dma_done_o, dma_wr_req_o, dma_wr_req_len_o, dma_wr_req_addr_o,
           dma_wr_data_o, fifo_rd_o
  );
endinterface

// File: rtl/ddr_pcie_chunk_calc.sv
// Chunk length = min(remaining, MAX_PAYLOAD_BYTES, bytes to next 4 KB boundary).
module ddr_pcie_chunk_calc
  import ddr_pcie_dma_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 128
) (
    input  logic [31:0] remaining_i,
    input  logic [11:0] addr_lo_i,
    output logic [11:0] chunk_len_o
);
    logic [12:0] rem_cap;
    logic [12:0] to_boundary;

    always_comb begin
        rem_cap     = (remaining_i > 32'(MAX_PAYLOAD_BYTES)) ? 13'(MAX_PAYLOAD_BYTES)
                                                             : remaining_i[12:0];
        to_boundary = 13'(BOUNDARY_BYTES) - {1'b0, addr_lo_i};
        // Result never exceeds MAX_PAYLOAD_BYTES (<= 512), so 12 bits suffice.
        chunk_len_o = 12'(min13(rem_cap, to_boundary));
    end
endmodule

// File: rtl/ddr_pcie_dma_controller.sv
// Splits a host write DMA into 4 KB-safe TLP chunks fed from the DDR read FIFO.
// Optional DDR_PCIE_DMA_STATS_EN adds a cumulative sent_bytes_o counter.
module ddr_pcie_dma_controller
  import ddr_pcie_dma_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 128
) (
    input  logic pcie_clk_i,
    input  logic rst_i,
    ddr_pcie_dma_controller_if.master bus
`ifdef DDR_PCIE_DMA_STATS_EN
    ,
    output logic [31:0] sent_bytes_o
`endif
);
    dma_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [11:0] len_q, len_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic [8:0]  words_q, words_d;
    logic        rd_dly_q, rd_dly_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [11:0] chunk_len;
    logic        fifo_rd;

    ddr_pcie_chunk_calc #(.MAX_PAYLOAD_BYTES(MAX_PAYLOAD_BYTES)) u_chunk (
        .remaining_i(rem_q),
        .addr_lo_i  (addr_q[11:0]),
        .chunk_len_o(chunk_len)
    );

    always_comb begin
        // Extra pulls past the chunk are dropped; no read during reset.
        fifo_rd    = (state_q == ST_XFER) && bus.dma_wr_data_rd_i && (words_q != '0) && !rst_i;
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        req_addr_d = req_addr_q;
        req_d      = req_q;
        done_d     = done_q;
        words_d    = words_q;
        rd_dly_d   = fifo_rd;
        wr_data_d  = rd_dly_q ? bus.fifo_data_i : wr_data_q;
        case (state_q)
            ST_IDLE: if (bus.ctrl_en_i) begin
                addr_d = bus.dma_dst_addr_i;
                rem_d  = bus.dma_len_i;
                if (bus.dma_len_i == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: if ({bus.fifo_data_cnt_i, 3'b000} >= {2'b00, chunk_len}) begin
                state_d    = ST_REQ;
                req_d      = 1'b1;
                len_d      = chunk_len;
                req_addr_d = addr_q;
                words_d    = chunk_len[11:3];
            end
            // An ack that arrives in the very first request cycle is honoured too.
            ST_REQ, ST_WAIT_ACK: begin
                if (bus.dma_wr_req_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_XFER: if (fifo_rd) begin
                words_d = words_q - 9'd1;
                if (words_q == 9'd1) begin
                    addr_d = addr_q + {20'd0, len_q};
                    rem_d  = rem_q - {20'd0, len_q};
                    if (rem_q == {20'd0, len_q}) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_DONE: if (!bus.ctrl_en_i && bus.dma_done_ack_i) begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            req_addr_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
            rd_dly_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            done_q     <= done_d;
            words_q    <= words_d;
            rd_dly_q   <= rd_dly_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.dma_done_o        = done_q;
    assign bus.dma_wr_req_o      = req_q;
    assign bus.dma_wr_req_len_o  = len_q;
    assign bus.dma_wr_req_addr_o = req_addr_q;
    assign bus.dma_wr_data_o     = wr_data_q;
    assign bus.fifo_rd_o         = fifo_rd;

`ifdef DDR_PCIE_DMA_STATS_EN
    logic [31:0] sent_q, sent_d;
    always_comb sent_d = fifo_rd ? sent_q + 32'(WORD_BYTES) : sent_q;
    always_ff @(posedge pcie_clk_i) begin
        if (rst_i) sent_q <= '0;
        else       sent_q <= sent_d;
    end
    assign sent_bytes_o = sent_q;
`endif
endmodule

// File: tb/tb_ddr_pcie_dma_controller.sv
// Scoreboard bench: expected chunk requests and FIFO words are queued as
// stimulus is produced and compared when the controller emits them.
module tb_ddr_pcie_dma_controller;
    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] len;
    } req_t;

    logic pcie_clk_i = 1'b0;
    logic rst_i;
    ddr_pcie_dma_controller_if bus();
`ifdef DDR_PCIE_DMA_STATS_EN
    logic [31:0] sent_bytes_o;
`endif

    ddr_pcie_dma_controller #(.MAX_PAYLOAD_BYTES(128)) dut (
        .pcie_clk_i(pcie_clk_i),
        .rst_i     (rst_i),
        .bus       (bus)
`ifdef DDR_PCIE_DMA_STATS_EN
        ,
        .sent_bytes_o(sent_bytes_o)
`endif
    );

    always #5 pcie_clk_i = ~pcie_clk_i;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          req_cnt = 0;
    int          rd_at_rst = 0;
    logic        rd_d1 = 1'b0, rd_d2 = 1'b0;
    logic [63:0] fifo_word = 64'hDEAD_0000_0000_0001;
    req_t        exp_req[$];
    logic [63:0] exp_data[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // DDR FIFO model: registered output, one-cycle read latency.
    always @(posedge pcie_clk_i) begin
        if (bus.dma_wr_req_o) req_cnt <= req_cnt + 1;
        if (rst_i) begin
            rd_d1 <= 1'b0;
            rd_d2 <= 1'b0;
            exp_data.delete();
            rd_at_rst <= rd_cnt;
        end else begin
            rd_d1 <= bus.fifo_rd_o;
            rd_d2 <= rd_d1;
            if (bus.fifo_rd_o) begin
                bus.fifo_data_i <= fifo_word;
                exp_data.push_back(fifo_word);
                fifo_word <= fifo_word + 64'h0101_0101_0101_0101;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    always @(negedge pcie_clk_i) begin
        if (rd_d2) begin
            if (exp_data.size() == 0) chk("data_q_empty", 64'd0, 64'd1);
            else chk("wr_data", bus.dma_wr_data_o, exp_data.pop_front());
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] l, input logic hold_en);
        bus.ctrl_en_i = 1'b1;
        bus.dma_dst_addr_i = a;
        bus.dma_len_i = l;
        @(negedge pcie_clk_i);
        bus.ctrl_en_i = hold_en;
    endtask

    task automatic wait_req(output req_t r);
        r = '0;
        for (int i = 0; i < 20 && !bus.dma_wr_req_o; i++) @(negedge pcie_clk_i);
        chk("req_seen", bus.dma_wr_req_o, 1);
        if (exp_req.size() == 0) chk("req_q_empty", 0, 1);
        else begin
            r = exp_req.pop_front();
            chk("req_addr", bus.dma_wr_req_addr_o, r.addr);
            chk("req_len", bus.dma_wr_req_len_o, r.len);
        end
        bus.dma_wr_req_ack_i = 1'b1;
        @(negedge pcie_clk_i);
        bus.dma_wr_req_ack_i = 1'b0;
        chk("req_drop", bus.dma_wr_req_o, 0);
    endtask

    task automatic serve_chunk();
        req_t r;
        int target;
        wait_req(r);
        target = rd_cnt + int'(r.len) / 8;
        for (int i = 0; i < 400 && rd_cnt < target; i++) begin
            bus.dma_wr_data_rd_i = ($urandom_range(0, 3) != 0);
            @(negedge pcie_clk_i);
        end
        // Surplus pulls after the last word must not reach the FIFO.
        bus.dma_wr_data_rd_i = 1'b1;
        repeat (2) @(negedge pcie_clk_i);
        bus.dma_wr_data_rd_i = 1'b0;
        chk("rd_words", rd_cnt, target);
    endtask

    task automatic finish_done();
        for (int i = 0; i < 20 && !bus.dma_done_o; i++) @(negedge pcie_clk_i);
        chk("done_set", bus.dma_done_o, 1);
        bus.ctrl_en_i = 1'b1;
        bus.dma_done_ack_i = 1'b1;
        @(negedge pcie_clk_i);
        chk("done_hold_en", bus.dma_done_o, 1);
        bus.ctrl_en_i = 1'b0;
        @(negedge pcie_clk_i);
        chk("done_clr", bus.dma_done_o, 0);
        bus.dma_done_ack_i = 1'b0;
    endtask

    initial begin
        int base;
        req_t r;
        rst_i = 1'b1;
        bus.ctrl_en_i = 1'b0;
        bus.dma_dst_addr_i = '0;
        bus.dma_len_i = '0;
        bus.dma_done_ack_i = 1'b0;
        bus.dma_wr_req_ack_i = 1'b0;
        bus.dma_wr_data_rd_i = 1'b0;
        bus.fifo_data_i = '0;
        bus.fifo_data_cnt_i = 11'd32;
        repeat (3) @(negedge pcie_clk_i);
        chk("rst_done", bus.dma_done_o, 0);
        chk("rst_req", bus.dma_wr_req_o, 0);
        chk("rst_len", bus.dma_wr_req_len_o, 0);
        chk("rst_addr", bus.dma_wr_req_addr_o, 0);
        chk("rst_data", bus.dma_wr_data_o, 0);
        chk("rst_rd", bus.fifo_rd_o, 0);
        rst_i = 1'b0;
        @(negedge pcie_clk_i);

        // Two full-payload chunks; ctrl_en dropped mid-transfer is ignored.
        base = rd_cnt;
        exp_req.push_back('{32'h1000, 12'd128});
        exp_req.push_back('{32'h1080, 12'd128});
        start(32'h1000, 32'd256, 1'b0);
        serve_chunk();
        serve_chunk();
        chk("t1_words", rd_cnt - base, 32);
        finish_done();

        // 4 KB boundary split.
        bus.fifo_data_cnt_i = 11'd64;
        exp_req.push_back('{32'h1FC0, 12'd64});
        exp_req.push_back('{32'h2000, 12'd64});
        start(32'h1FC0, 32'd128, 1'b1);
        serve_chunk();
        serve_chunk();
        finish_done();

        // Zero length: straight to DONE, no request.
        base = req_cnt;
        start(32'h5000, 32'd0, 1'b0);
        chk("len0_done", bus.dma_done_o, 1);
        finish_done();
        chk("len0_noreq", req_cnt - base, 0);

        // Insufficient FIFO fill holds WAIT_DATA.
        bus.fifo_data_cnt_i = 11'd8;
        exp_req.push_back('{32'h0000_0000, 12'd128});
        start(32'h0, 32'd128, 1'b0);
        base = req_cnt;
        repeat (6) @(negedge pcie_clk_i);
        chk("wait_data_hold", req_cnt - base, 0);
        bus.fifo_data_cnt_i = 11'd16;
        for (int i = 0; i < 2 && !bus.dma_wr_req_o; i++) @(negedge pcie_clk_i);
        chk("req_within_2", bus.dma_wr_req_o, 1);
        serve_chunk();
        finish_done();

        // Reset mid-XFER after 5 words.
        bus.fifo_data_cnt_i = 11'd64;
        exp_req.push_back('{32'h3000, 12'd128});
        start(32'h3000, 32'd128, 1'b0);
        wait_req(r);
        base = rd_cnt + 5;
        bus.dma_wr_data_rd_i = 1'b1;
        for (int i = 0; i < 50 && rd_cnt < base; i++) @(negedge pcie_clk_i);
        rst_i = 1'b1;
        #1;
        chk("rd_in_reset", bus.fifo_rd_o, 0);
        @(negedge pcie_clk_i);
        bus.dma_wr_data_rd_i = 1'b0;
        chk("mid_rst_words", rd_cnt, base);
        chk("mid_rst_done", bus.dma_done_o, 0);
        chk("mid_rst_req", bus.dma_wr_req_o, 0);
        chk("mid_rst_len", bus.dma_wr_req_len_o, 0);
        chk("mid_rst_addr", bus.dma_wr_req_addr_o, 0);
        chk("mid_rst_data", bus.dma_wr_data_o, 0);
        rst_i = 1'b0;
        @(negedge pcie_clk_i);
        exp_req.push_back('{32'h3000, 12'd64});
        start(32'h3000, 32'd64, 1'b0);
        serve_chunk();
        finish_done();
`ifdef DDR_PCIE_DMA_STATS_EN
        chk("sent_bytes", sent_bytes_o, 32'(8 * (rd_cnt - rd_at_rst)));
`endif
        repeat (4) @(negedge pcie_clk_i);
        chk("data_drained", exp_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
